// File: rtl/flag_hazard_ctrl_pkg.sv
// Shared processor constants for the flag hazard controller:
// default in-flight depth and the carry/zero flag indices.
package flag_hazard_ctrl_pkg;

  // Un-retired writers per flag: one each in EX, MEM and WB
  localparam int MAX_INFLIGHT_DEF = 3;

  // Flag indices used for the per-flag vectors in the controller
  typedef enum logic [0:0] {
    FLAG_C = 1'b0,
    FLAG_Z = 1'b1
  } flag_idx_e;

  localparam int NUM_FLAGS = 2;

  // Counter width needed to hold the values 0..max_inflight
  function automatic int pend_width(input int max_inflight);
    return $clog2(max_inflight + 1);
  endfunction

endpackage

// File: rtl/flag_pend_counter.sv
// Counts the in-flight writers of one condition flag.
// A clear overrides everything. A simultaneous increment and decrement
// leaves the count unchanged. An illegal step (decrement at zero or
// increment at the limit) holds the count and raises err for one cycle.
module flag_pend_counter
  import flag_hazard_ctrl_pkg::*;
#(
  parameter int MAX = MAX_INFLIGHT_DEF,
  parameter int CW  = pend_width(MAX_INFLIGHT_DEF)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          dec,
  input  logic          clr,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          err
);

  localparam logic [CW-1:0] MAX_CNT = CW'(MAX);
  localparam logic [CW-1:0] ONE     = CW'(1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  assign count = count_q;
  assign full  = (count_q == MAX_CNT);
  assign empty = (count_q == '0);

  // A retire with nothing pending is an underflow even during a flush,
  // because WB is older than the flush point.
  assign err = (dec & ~inc & empty) | (~clr & inc & ~dec & full);

  // Next-count selection: clear, then +1 / -1, saturating at both ends
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && !dec) begin
      if (!full) count_d = count_q + ONE;
    end else if (dec && !inc) begin
      if (!empty) count_d = count_q - ONE;
    end
  end

  // Count register, cleared asynchronously by the active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) count_q <= '0;
    else      count_q <= count_d;
  end

endmodule

// File: rtl/flag_hazard_ctrl.sv
// Carry/zero flag hazard controller: stalls decode while a flag it reads
// has un-retired writers (or its writer tracking is full), forwards WB
// flag writes to the flag register and keeps a sticky error bit.
module flag_hazard_ctrl
  import flag_hazard_ctrl_pkg::*;
#(
  parameter int MAX_INFLIGHT = MAX_INFLIGHT_DEF,
  localparam int CW = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          id_valid,
  input  logic          id_rd_c,
  input  logic          id_rd_z,
  input  logic          id_wr_c,
  input  logic          id_wr_z,
  output logic          id_stall,
  input  logic          flush,
  input  logic          wb_valid,
  input  logic          wb_wr_c,
  input  logic          wb_wr_z,
  input  logic          wb_carry,
  input  logic          wb_zero,
  output logic          carry_wr,
  output logic          zero_wr,
  output logic          carry_in,
  output logic          zero_in,
  output logic [CW-1:0] pend_c,
  output logic [CW-1:0] pend_z,
  output logic          err
);

  logic [NUM_FLAGS-1:0] rd_vec;
  logic [NUM_FLAGS-1:0] wr_vec;
  logic [NUM_FLAGS-1:0] retire_vec;
  logic [NUM_FLAGS-1:0] full_vec;
  logic [NUM_FLAGS-1:0] empty_vec;
  logic [NUM_FLAGS-1:0] err_vec;
  logic [NUM_FLAGS-1:0] stall_vec;
  logic [CW-1:0]        count_arr [NUM_FLAGS];
  logic                 issue;
  logic                 err_q;
  logic                 err_d;

  assign rd_vec[FLAG_C]     = id_rd_c;
  assign rd_vec[FLAG_Z]     = id_rd_z;
  assign wr_vec[FLAG_C]     = id_wr_c;
  assign wr_vec[FLAG_Z]     = id_wr_z;
  assign retire_vec[FLAG_C] = wb_valid & wb_wr_c;
  assign retire_vec[FLAG_Z] = wb_valid & wb_wr_z;

  // A full tracker only blocks a new writer if no slot frees up this cycle
  assign id_stall = id_valid & (|stall_vec);
  assign issue    = id_valid & ~id_stall & ~flush;

  // WB is older than any flush, so retiring writes always reach the register
  assign carry_wr = retire_vec[FLAG_C];
  assign zero_wr  = retire_vec[FLAG_Z];
  assign carry_in = wb_carry;
  assign zero_in  = wb_zero;

  assign pend_c = count_arr[FLAG_C];
  assign pend_z = count_arr[FLAG_Z];
  assign err    = err_q;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_FLAGS; gi++) begin : g_flag
      assign stall_vec[gi] = (rd_vec[gi] & ~empty_vec[gi]) |
                             (wr_vec[gi] & full_vec[gi] & ~retire_vec[gi]);

      flag_pend_counter #(
        .MAX (MAX_INFLIGHT),
        .CW  (CW)
      ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (issue & wr_vec[gi]),
        .dec   (retire_vec[gi]),
        .clr   (flush),
        .count (count_arr[gi]),
        .full  (full_vec[gi]),
        .empty (empty_vec[gi]),
        .err   (err_vec[gi])
      );
    end
  endgenerate

  // Error accumulates any counter misuse until the next reset
  always_comb begin
    err_d = err_q | (|err_vec);
  end

  // Sticky error register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_q <= 1'b0;
    else      err_q <= err_d;
  end

endmodule

// File: tb/tb_flag_hazard_ctrl.sv
// Directed scoreboard bench for flag_hazard_ctrl: each driven cycle pushes
// its hand-computed expectation; a negedge monitor pops and compares.
module tb_flag_hazard_ctrl;

  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          id_valid = 0, id_rd_c = 0, id_rd_z = 0, id_wr_c = 0, id_wr_z = 0;
  logic          flush = 0, wb_valid = 0, wb_wr_c = 0, wb_wr_z = 0;
  logic          wb_carry = 0, wb_zero = 0;
  logic          id_stall, carry_wr, zero_wr, carry_in, zero_in, err;
  logic [CW-1:0] pend_c, pend_z;

  flag_hazard_ctrl #(.MAX_INFLIGHT(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .id_valid (id_valid),
    .id_rd_c  (id_rd_c),
    .id_rd_z  (id_rd_z),
    .id_wr_c  (id_wr_c),
    .id_wr_z  (id_wr_z),
    .id_stall (id_stall),
    .flush    (flush),
    .wb_valid (wb_valid),
    .wb_wr_c  (wb_wr_c),
    .wb_wr_z  (wb_wr_z),
    .wb_carry (wb_carry),
    .wb_zero  (wb_zero),
    .carry_wr (carry_wr),
    .zero_wr  (zero_wr),
    .carry_in (carry_in),
    .zero_in  (zero_in),
    .pend_c   (pend_c),
    .pend_z   (pend_z),
    .err      (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          stall;
    logic          cwr;
    logic          zwr;
    logic          cin;
    logic          zin;
    logic [CW-1:0] pc;
    logic [CW-1:0] pz;
    logic          er;
  } exp_t;

  exp_t  exp_q  [$];
  string name_q [$];
  int    n_cmp = 0;
  int    n_bad = 0;
  bit    stim_done = 0;

  task automatic chk(input string tr, input string field, input int act, input int want);
    n_cmp++;
    if (act != want) begin
      n_bad++;
      $display("FAIL %s.%s: got %0d expected %0d", tr, field, act, want);
    end
  endtask

  // Monitor: one transaction per cycle, sampled mid-cycle
  initial begin
    exp_t  e;
    string nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        chk(nm, "id_stall", int'(id_stall), int'(e.stall));
        chk(nm, "carry_wr", int'(carry_wr), int'(e.cwr));
        chk(nm, "zero_wr",  int'(zero_wr),  int'(e.zwr));
        chk(nm, "carry_in", int'(carry_in), int'(e.cin));
        chk(nm, "zero_in",  int'(zero_in),  int'(e.zin));
        chk(nm, "pend_c",   int'(pend_c),   int'(e.pc));
        chk(nm, "pend_z",   int'(pend_z),   int'(e.pz));
        chk(nm, "err",      int'(err),      int'(e.er));
        $display("txn %-12s stall=%0d cwr=%0d zwr=%0d cin=%0d zin=%0d pend_c=%0d pend_z=%0d err=%0d",
                 nm, id_stall, carry_wr, zero_wr, carry_in, zero_in, pend_c, pend_z, err);
      end
    end
  end

  // in: {rst, v, rdc, rdz, wrc, wrz, fl, wbv, wbwc, wbwz, wbcarry, wbzero}
  // ex: {stall, cwr, zwr, cin, zin, pc, pz, err}
  task automatic drive(input string nm, input logic [11:0] in, input exp_t ex);
    @(posedge clk);
    #1;
    {rst, id_valid, id_rd_c, id_rd_z, id_wr_c, id_wr_z,
     flush, wb_valid, wb_wr_c, wb_wr_z, wb_carry, wb_zero} = in;
    exp_q.push_back(ex);
    name_q.push_back(nm);
  endtask

  function automatic exp_t mk(input logic s, input logic cw, input logic zw,
                              input logic ci, input logic zi,
                              input int pc, input int pz, input logic er);
    exp_t e;
    e.stall = s; e.cwr = cw; e.zwr = zw; e.cin = ci; e.zin = zi;
    e.pc = CW'(pc); e.pz = CW'(pz); e.er = er;
    return e;
  endfunction

  initial begin
    //                     r v rc rz wc wz f wv wc wz cy zr
    // Reset held: reading carry with nothing pending never stalls
    drive("rst_rdc",  12'b0_1_1_0_0_0_0_0_0_0_0_0, mk(0,0,0,0,0, 0,0,0));
    drive("rst_idle", 12'b0_0_0_0_0_0_0_0_0_0_0_0, mk(0,0,0,0,0, 0,0,0));
    drive("rel",      12'b1_0_0_0_0_0_0_0_0_0_0_0, mk(0,0,0,0,0, 0,0,0));
    // Carry writer then dependent reader: stalls until retire
    drive("wr_c0",    12'b1_1_0_0_1_0_0_0_0_0_0_0, mk(0,0,0,0,0, 0,0,0));
    drive("rd_c1",    12'b1_1_1_0_0_0_0_0_0_0_0_0, mk(1,0,0,0,0, 1,0,0));
    drive("rd_c2",    12'b1_1_1_0_0_0_0_0_0_0_0_0, mk(1,0,0,0,0, 1,0,0));
    drive("rd_c3_ret",12'b1_1_1_0_0_0_0_1_1_0_1_0, mk(1,1,0,1,0, 1,0,0));
    drive("rd_c4",    12'b1_1_1_0_0_0_0_0_0_0_0_0, mk(0,0,0,0,0, 0,0,0));
    // Fill zero tracker to the limit
    drive("wz1",      12'b1_1_0_0_0_1_0_0_0_0_0_0, mk(0,0,0,0,0, 0,0,0));
    drive("wz2",      12'b1_1_0_0_0_1_0_0_0_0_0_0, mk(0,0,0,0,0, 0,1,0));
    drive("wz3",      12'b1_1_0_0_0_1_0_0_0_0_0_0, mk(0,0,0,0,0, 0,2,0));
    drive("wz4_stall",12'b1_1_0_0_0_1_0_0_0_0_0_0, mk(1,0,0,0,0, 0,3,0));
    drive("wz4_ret",  12'b1_1_0_0_0_1_0_1_0_1_0_1, mk(0,0,1,0,1, 0,3,0));
    drive("pz3_chk",  12'b1_0_0_0_0_0_0_0_0_0_0_0, mk(0,0,0,0,0, 0,3,0));
    drive("rz_a",     12'b1_0_0_0_0_0_0_1_0_1_0_0, mk(0,0,1,0,0, 0,3,0));
    drive("rz_b",     12'b1_0_0_0_0_0_0_1_0_1_0_0, mk(0,0,1,0,0, 0,2,0));
    drive("rz_c",     12'b1_0_0_0_0_0_0_1_0_1_0_0, mk(0,0,1,0,0, 0,1,0));
    // Two carry writers then flush with a same-cycle carry retire
    drive("wc_a",     12'b1_1_0_0_1_0_0_0_0_0_0_0, mk(0,0,0,0,0, 0,0,0));
    drive("wc_b",     12'b1_1_0_0_1_0_0_0_0_0_0_0, mk(0,0,0,0,0, 1,0,0));
    drive("fl_ret",   12'b1_0_0_0_0_0_1_1_1_0_1_0, mk(0,1,0,1,0, 2,0,0));
    drive("fl_chk",   12'b1_0_0_0_0_0_0_0_0_0_0_0, mk(0,0,0,0,0, 0,0,0));
    // Zero read ignores pending carry; carry issue+retire holds count
    drive("wc_c",     12'b1_1_0_0_1_0_0_0_0_0_0_0, mk(0,0,0,0,0, 0,0,0));
    drive("rdz_free", 12'b1_1_0_1_0_0_0_0_0_0_0_0, mk(0,0,0,0,0, 1,0,0));
    drive("c_iss_ret",12'b1_1_0_0_1_0_0_1_1_0_0_0, mk(0,1,0,0,0, 1,0,0));
    drive("c_hold",   12'b1_0_0_0_0_0_0_0_0_0_0_0, mk(0,0,0,0,0, 1,0,0));
    // Flush blocks a writer in decode and clears the count
    drive("fl_noiss", 12'b1_1_0_0_1_0_1_0_0_0_0_0, mk(0,0,0,0,0, 1,0,0));
    drive("fl_chk2",  12'b1_0_0_0_0_0_0_0_0_0_0_0, mk(0,0,0,0,0, 0,0,0));
    // Zero underflow sets a sticky error, cleared only by reset
    drive("z_under",  12'b1_0_0_0_0_0_0_1_0_1_0_1, mk(0,0,1,0,1, 0,0,0));
    drive("err_set",  12'b1_0_0_0_0_0_0_0_0_0_0_0, mk(0,0,0,0,0, 0,0,1));
    drive("err_hold", 12'b1_1_0_0_1_0_0_0_0_0_0_0, mk(0,0,0,0,0, 0,0,1));
    drive("rst_clr",  12'b0_0_0_0_0_0_0_0_0_0_0_0, mk(0,0,0,0,0, 0,0,0));
    drive("post_rst", 12'b1_0_0_0_0_0_0_0_0_0_0_0, mk(0,0,0,0,0, 0,0,0));
    stim_done = 1;
  end

  // Drain the scoreboard within a bounded number of cycles
  initial begin
    wait (stim_done);
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Absolute time limit
  initial begin
    #20000;
    $display("FAIL timeout: got no completion expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/flag_hazard_ctrl.md
FLAG_HAZARD_CTRL -- requirements
Module: flag_hazard_ctrl

Interface
REQ-001 SHALL have parameter MAX_INFLIGHT, default 3, meaning max un-retired writers per flag (EX, MEM, WB).
REQ-002 SHALL have port clk  input  1  single system clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port id_valid  input  1  instruction present in decode.
REQ-005 SHALL have ports id_rd_c, id_rd_z  input  1 each  decode instruction reads carry / zero.
REQ-006 SHALL have ports id_wr_c, id_wr_z  input  1 each  decode instruction will write carry / zero.
REQ-007 SHALL have port id_stall  output  1  hold decode this cycle.
REQ-008 SHALL have port flush  input  1  kill all instructions younger than WB (EX, MEM, ID).
REQ-009 SHALL have ports wb_valid, wb_wr_c, wb_wr_z  input  1 each  retiring instruction and its flag writes.
REQ-010 SHALL have ports wb_carry, wb_zero  input  1 each  flag values produced by the retiring instruction.
REQ-011 SHALL have ports carry_wr, zero_wr, carry_in, zero_in  output  1 each  write controls/data to flag register.
REQ-012 SHALL have port pend_c, pend_z  output  CW each  in-flight writer counts, CW = clog2(MAX_INFLIGHT+1).
REQ-013 SHALL have port err  output  1  sticky underflow/overflow error.

Function
REQ-014 SHALL define issue = id_valid & ~id_stall & ~flush.
REQ-015 SHALL define retire_c = wb_valid & wb_wr_c; retire_z = wb_valid & wb_wr_z.
REQ-016 SHALL assert id_stall combinationally when id_valid and any: (id_rd_c & pend_c!=0), (id_rd_z & pend_z!=0), (id_wr_c & pend_c==MAX_INFLIGHT & ~retire_c), (id_wr_z & pend_z==MAX_INFLIGHT & ~retire_z).
REQ-017 SHALL drive carry_wr = retire_c, zero_wr = retire_z, carry_in = wb_carry, zero_in = wb_zero, combinationally, zero added latency; flag register captures on same edge counters decrement.
REQ-018 SHALL update pend_c on each edge: flush -> 0; else +1 if (issue & id_wr_c), -1 if retire_c, unchanged if both or neither; pend_z identically.
REQ-019 SHALL let a WB retire in a flush cycle still drive carry_wr/zero_wr (WB is older than flush point).
REQ-020 SHALL, on retire with counter already 0 (and no same-cycle issue), hold counter at 0 and set err.
REQ-021 SHALL, on increment with counter at MAX_INFLIGHT and no retire, hold counter and set err (unreachable if REQ-016 honoured).
REQ-022 SHALL keep err set until reset.
REQ-023 SHALL not stall reads of a flag whose pend count is 0, regardless of the other flag's count.
REQ-024 SHALL treat id_rd/id_wr inputs as don't-care when id_valid=0.

Reset
REQ-025 SHALL, while rst=0, asynchronously force pend_c=0, pend_z=0, err=0.
REQ-026 SHALL produce id_stall=0 and carry_wr=zero_wr=0 during reset when id_valid=0 and wb_valid=0; reset mid-operation discards all pending counts.
REQ-027 SHALL release reset synchronously to clk via external synchronizer; block makes no assumption of first-cycle inputs.

Structure
REQ-028 SHALL place MAX_INFLIGHT default and the flag-index constants (C=0, Z=1) in the shared processor package.
REQ-029 SHALL implement both flags via one sub-module flag_pend_counter (inc, dec, clr, count, full, empty, err), instantiated twice.
REQ-030 SHALL contain no FSM beyond the two counters and err; total RTL 120-400 lines.

Verification
REQ-031 SHALL test: reset low with id_valid=1,id_rd_c=1 -> id_stall=0, pend_c=0; after release pend_c=0.
REQ-032 SHALL test: issue writer id_wr_c=1 cycle 0, reader id_rd_c=1 cycle 1 -> id_stall=1 cycles 1-3 with pend_c=1; retire_c cycle 3 -> carry_wr=1 cycle 3, id_stall=0 cycle 4.
REQ-033 SHALL test: three back-to-back id_wr_z issues -> pend_z=3; fourth id_wr_z stalls; with same-cycle retire_z fourth issues, pend_z stays 3.
REQ-034 SHALL test: pend_c=2, flush=1 with retire_c=1 -> carry_wr=1 that cycle, pend_c=0 next cycle, err=0.
REQ-035 SHALL test: pend_z=0, wb_valid=1,wb_wr_z=1 -> pend_z=0, err=1 and held until rst=0.
REQ-036 SHALL test: pend_c=1, pend_z=0, reader id_rd_z=1 -> id_stall=0; same-cycle issue+retire on carry -> pend_c unchanged.
